// File: rtl/rename_pkg.sv
// Shared rename/retire definitions: tag and queue geometry, the retire-queue entry,
// and the wakeup tag-match helper used by both dispatch bypass and completion.
package rename_pkg;

  localparam int unsigned TAG_W      = 6;
  localparam int unsigned DEPTH      = 16;
  localparam int unsigned IDX_W      = $clog2(DEPTH);
  localparam int unsigned PTR_W      = IDX_W + 1;
  localparam int unsigned NUM_WAKEUP = 4;

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    logic valid;
    logic done;
    tag_t physical_rd;
    tag_t old_physical_rd;
  } rq_entry_t;

  // Tag 0 is the zero register and never matches a broadcast.
  function automatic logic tag_hit(input logic [NUM_WAKEUP-1:0]            act,
                                   input logic [NUM_WAKEUP-1:0][TAG_W-1:0] tags,
                                   input tag_t                             tag);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_WAKEUP; k++) begin
      if (act[k] && (tags[k] == tag) && (tag != '0)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/retire_select.sv
// Picks up to two in-order retirees from the head pair and forms their freed tags.
module retire_select
  import rename_pkg::*;
(
  input  rq_entry_t head_entry,
  input  rq_entry_t next_entry,
  output logic      r0_c,
  output logic      r1_c,
  output tag_t      freed_1_c,
  output tag_t      freed_2_c
);

  always_comb begin
    r0_c      = head_entry.valid && head_entry.done;
    r1_c      = r0_c && next_entry.valid && next_entry.done;
    freed_1_c = r0_c ? head_entry.old_physical_rd : '0;
    freed_2_c = r1_c ? next_entry.old_physical_rd : '0;
  end

endmodule

// File: rtl/retire_queue.sv
// In-order retire buffer: tracks completion of renamed instructions and returns
// displaced tags to the free list, up to two per cycle.
module retire_queue
  import rename_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             dispatch_valid,
  input  logic [TAG_W-1:0] dispatch_physical_rd,
  input  logic [TAG_W-1:0] dispatch_old_physical_rd,
  output logic             dispatch_ready,
  output logic [IDX_W-1:0] dispatch_index,
  input  logic             wakeup_0_active,
  input  logic [TAG_W-1:0] wakeup_0_tag,
  input  logic             wakeup_1_active,
  input  logic [TAG_W-1:0] wakeup_1_tag,
  input  logic             wakeup_2_active,
  input  logic [TAG_W-1:0] wakeup_2_tag,
  input  logic             wakeup_3_active,
  input  logic [TAG_W-1:0] wakeup_3_tag,
  output logic [TAG_W-1:0] freed_tag_1,
  output logic [TAG_W-1:0] freed_tag_2,
  output logic [1:0]       retire_count,
  output logic             empty,
  output logic             full
);

  rq_entry_t        entries_q [DEPTH];
  rq_entry_t        entries_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  tag_t             freed_1_q, freed_1_d, freed_2_q, freed_2_d;
  logic [1:0]       retire_count_q, retire_count_d;

  logic [NUM_WAKEUP-1:0]            wk_act;
  logic [NUM_WAKEUP-1:0][TAG_W-1:0] wk_tags;
  logic [IDX_W-1:0]                 head_idx, next_idx, tail_idx;
  logic                             r0, r1, accept;
  tag_t                             sel_freed_1, sel_freed_2;

  assign wk_act  = {wakeup_3_active, wakeup_2_active, wakeup_1_active, wakeup_0_active};
  assign wk_tags = {wakeup_3_tag, wakeup_2_tag, wakeup_1_tag, wakeup_0_tag};

  assign head_idx = head_q[IDX_W-1:0];
  assign next_idx = head_idx + IDX_W'(1);
  assign tail_idx = tail_q[IDX_W-1:0];

  // Wrap bit distinguishes full from empty when the low bits coincide.
  assign empty          = (head_q == tail_q);
  assign full           = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign dispatch_ready = !full;
  assign dispatch_index = tail_idx;
  assign accept         = dispatch_valid && !full;

  retire_select u_select (
    .head_entry (entries_q[head_idx]),
    .next_entry (entries_q[next_idx]),
    .r0_c       (r0),
    .r1_c       (r1),
    .freed_1_c  (sel_freed_1),
    .freed_2_c  (sel_freed_2)
  );

  always_comb begin
    entries_d      = entries_q;
    freed_1_d      = sel_freed_1;
    freed_2_d      = sel_freed_2;
    retire_count_d = {1'b0, r0} + {1'b0, r1};
    head_d         = head_q + PTR_W'(retire_count_d);
    tail_d         = tail_q + PTR_W'(accept);

    for (int i = 0; i < DEPTH; i++) begin
      if (entries_q[i].valid && tag_hit(wk_act, wk_tags, entries_q[i].physical_rd)) begin
        entries_d[i].done = 1'b1;
      end
    end

    if (r0) entries_d[head_idx].valid = 1'b0;
    if (r1) entries_d[next_idx].valid = 1'b0;

    // Tail slot is never a retiree when not full, so this write cannot collide.
    if (accept) begin
      entries_d[tail_idx].valid           = 1'b1;
      entries_d[tail_idx].done            = (dispatch_physical_rd == '0) ||
                                            tag_hit(wk_act, wk_tags, dispatch_physical_rd);
      entries_d[tail_idx].physical_rd     = dispatch_physical_rd;
      entries_d[tail_idx].old_physical_rd = dispatch_old_physical_rd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      freed_1_q      <= '0;
      freed_2_q      <= '0;
      retire_count_q <= '0;
    end else begin
      entries_q      <= entries_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      freed_1_q      <= freed_1_d;
      freed_2_q      <= freed_2_d;
      retire_count_q <= retire_count_d;
    end
  end

  assign freed_tag_1  = freed_1_q;
  assign freed_tag_2  = freed_2_q;
  assign retire_count = retire_count_q;

endmodule

// File: tb/tb_retire_queue.sv
// Scoreboard bench for retire_queue: a queue-level program-order model plus a
// freed-tag scoreboard filled at dispatch and drained by a negedge monitor.
module tb_retire_queue;
  import rename_pkg::*;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             dispatch_valid = 1'b0;
  logic [TAG_W-1:0] dispatch_physical_rd = '0;
  logic [TAG_W-1:0] dispatch_old_physical_rd = '0;
  logic             dispatch_ready;
  logic [IDX_W-1:0] dispatch_index;
  logic             wakeup_0_active = 1'b0, wakeup_1_active = 1'b0;
  logic             wakeup_2_active = 1'b0, wakeup_3_active = 1'b0;
  logic [TAG_W-1:0] wakeup_0_tag = '0, wakeup_1_tag = '0, wakeup_2_tag = '0, wakeup_3_tag = '0;
  logic [TAG_W-1:0] freed_tag_1, freed_tag_2;
  logic [1:0]       retire_count;
  logic             empty, full;

  retire_queue dut (
    .clk(clk), .reset(reset),
    .dispatch_valid(dispatch_valid),
    .dispatch_physical_rd(dispatch_physical_rd),
    .dispatch_old_physical_rd(dispatch_old_physical_rd),
    .dispatch_ready(dispatch_ready), .dispatch_index(dispatch_index),
    .wakeup_0_active(wakeup_0_active), .wakeup_0_tag(wakeup_0_tag),
    .wakeup_1_active(wakeup_1_active), .wakeup_1_tag(wakeup_1_tag),
    .wakeup_2_active(wakeup_2_active), .wakeup_2_tag(wakeup_2_tag),
    .wakeup_3_active(wakeup_3_active), .wakeup_3_tag(wakeup_3_tag),
    .freed_tag_1(freed_tag_1), .freed_tag_2(freed_tag_2),
    .retire_count(retire_count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct { int prd; int old; bit done; } mentry_t;

  mentry_t mq[$];     // in-flight instructions, oldest first
  int      sb_q[$];   // expected freed tags in program order
  int      exp_rc = 0;
  int      m_tail = 0;
  int      checks = 0;
  int      failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_hit(input int t);
    if (t == 0) return 1'b0;
    return (wakeup_0_active && int'(wakeup_0_tag) == t) || (wakeup_1_active && int'(wakeup_1_tag) == t) ||
           (wakeup_2_active && int'(wakeup_2_tag) == t) || (wakeup_3_active && int'(wakeup_3_tag) == t);
  endfunction

  // Reference model: retire the done prefix (max two), then apply completions and dispatch.
  always @(posedge clk) begin : model
    int n;
    bit was_full;
    mentry_t e;
    if (reset) begin
      mq.delete();
      sb_q.delete();
      exp_rc = 0;
      m_tail = 0;
    end else begin
      n = 0;
      was_full = (mq.size() >= DEPTH);
      if (mq.size() > 0 && mq[0].done) n = 1;
      if (n == 1 && mq.size() > 1 && mq[1].done) n = 2;
      foreach (mq[i]) if (m_hit(mq[i].prd)) mq[i].done = 1'b1;
      repeat (n) void'(mq.pop_front());
      exp_rc = n;
      if (dispatch_valid && !was_full) begin
        e.prd  = int'(dispatch_physical_rd);
        e.old  = int'(dispatch_old_physical_rd);
        e.done = (e.prd == 0) || m_hit(e.prd);
        mq.push_back(e);
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
  end

  // Monitor: compare status every cycle and drain the scoreboard for each retiree.
  always @(negedge clk) begin : monitor
    int exp_tag;
    if (!reset) begin
      chk("retire_count", int'(retire_count), exp_rc);
      chk("empty", int'(empty), int'(mq.size() == 0));
      chk("full", int'(full), int'(mq.size() == DEPTH));
      chk("dispatch_ready", int'(dispatch_ready), int'(mq.size() < DEPTH));
      chk("dispatch_index", int'(dispatch_index), m_tail);
      for (int k = 0; k < 2; k++) begin
        exp_tag = 0;
        if (k < exp_rc) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow: got empty scoreboard expected an entry at %0t", $time);
          end else begin
            exp_tag = sb_q.pop_front();
          end
        end
        chk(k == 0 ? "freed_tag_1" : "freed_tag_2",
            k == 0 ? int'(freed_tag_1) : int'(freed_tag_2), exp_tag);
      end
    end
  end

  task automatic tick(input bit dv, input int p, input int o, input logic [3:0] act,
                      input int t0, input int t1, input int t2, input int t3);
    dispatch_valid           = dv;
    dispatch_physical_rd     = TAG_W'(p);
    dispatch_old_physical_rd = TAG_W'(o);
    {wakeup_3_active, wakeup_2_active, wakeup_1_active, wakeup_0_active} = act;
    wakeup_0_tag = TAG_W'(t0);
    wakeup_1_tag = TAG_W'(t1);
    wakeup_2_tag = TAG_W'(t2);
    wakeup_3_tag = TAG_W'(t3);
    if (dv && mq.size() < DEPTH) sb_q.push_back(o);
    @(negedge clk);
  endtask

  task automatic idle();
    tick(1'b0, 0, 0, 4'h0, 0, 0, 0, 0);
  endtask

  function automatic int pick_tag();
    if (mq.size() == 0) return int'($urandom_range(1, 63));
    return mq[$urandom_range(0, mq.size() - 1)].prd;
  endfunction

  initial begin
    logic [3:0] act;
    repeat (2) @(negedge clk);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_ready", int'(dispatch_ready), 1);
    chk("rst_retire_count", int'(retire_count), 0);
    chk("rst_freed_1", int'(freed_tag_1), 0);
    chk("rst_freed_2", int'(freed_tag_2), 0);
    reset = 1'b0;

    chk("index_first", int'(dispatch_index), 0);
    tick(1'b1, 33, 1, 4'h0, 0, 0, 0, 0);
    chk("index_second", int'(dispatch_index), 1);
    tick(1'b1, 34, 33, 4'h0, 0, 0, 0, 0);
    chk("two_empty", int'(empty), 0);
    tick(1'b0, 0, 0, 4'h1, 34, 0, 0, 0);
    tick(1'b0, 0, 0, 4'h1, 33, 0, 0, 0);
    chk("young_done_no_retire", int'(retire_count), 0);
    idle();
    chk("pair_retire_count", int'(retire_count), 2);
    chk("pair_freed_1", int'(freed_tag_1), 1);
    chk("pair_freed_2", int'(freed_tag_2), 33);
    chk("pair_empty", int'(empty), 1);
    idle();
    chk("pulse_freed_1", int'(freed_tag_1), 0);
    chk("pulse_freed_2", int'(freed_tag_2), 0);

    tick(1'b1, 0, 0, 4'h0, 0, 0, 0, 0);
    chk("x0_not_same_edge", int'(retire_count), 0);
    idle();
    chk("x0_retire_count", int'(retire_count), 1);
    chk("x0_freed_1", int'(freed_tag_1), 0);

    for (int i = 0; i < 16; i++) tick(1'b1, 40 + i, i + 1, 4'h0, 0, 0, 0, 0);
    chk("fill_full", int'(full), 1);
    chk("fill_ready", int'(dispatch_ready), 0);
    tick(1'b1, 60, 61, 4'h0, 0, 0, 0, 0);
    chk("refused_index", int'(dispatch_index), 3);
    tick(1'b0, 0, 0, 4'h1, 40, 0, 0, 0);
    chk("still_full", int'(full), 1);
    idle();
    chk("head_retire_count", int'(retire_count), 1);
    chk("head_freed_1", int'(freed_tag_1), 1);
    chk("ready_after_retire", int'(dispatch_ready), 1);
    for (int i = 1; i < 16; i += 4) tick(1'b0, 0, 0, 4'hf, 40 + i, 41 + i, 42 + i, 43 + i);
    repeat (4) idle();

    // Randomized traffic: pointers wrap several times.
    for (int c = 0; c < 600; c++) begin
      act = 4'($urandom_range(0, 15));
      tick(1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63)),
           int'($urandom_range(0, 63)), act,
           pick_tag(), pick_tag(), pick_tag(), pick_tag());
    end

    for (int c = 0; c < 20 && mq.size() > 0; c++) begin
      tick(1'b0, 0, 0, 4'hf, mq[0].prd,
           mq.size() > 1 ? mq[1].prd : 0, mq.size() > 2 ? mq[2].prd : 0,
           mq.size() > 3 ? mq[3].prd : 0);
    end
    repeat (3) idle();
    chk("drained_empty", int'(empty), 1);

    for (int i = 0; i < 4; i++) tick(1'b1, 10 + i, 2 + i, 4'h0, 0, 0, 0, 0);
    tick(1'b1, 14, 6, 4'h3, 12, 13, 0, 0);
    chk("mid_no_retire", int'(retire_count), 0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_empty", int'(empty), 1);
    chk("mid_rst_full", int'(full), 0);
    chk("mid_rst_ready", int'(dispatch_ready), 1);
    chk("mid_rst_index", int'(dispatch_index), 0);
    chk("mid_rst_retire_count", int'(retire_count), 0);
    chk("mid_rst_freed_1", int'(freed_tag_1), 0);
    @(negedge clk);
    reset = 1'b0;
    tick(1'b0, 0, 0, 4'h3, 10, 11, 0, 0);
    repeat (4) idle();
    chk("post_rst_freed_1", int'(freed_tag_1), 0);
    chk("post_rst_empty", int'(empty), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
